seg7_word_decoder: RTL and testbench
====================================

Name: seg7_word_decoder

Overview:
- Receiver-side counterpart of the team's hex-to-seven-segment encoder. Accepts a stream of active-low 7-segment patterns over a valid/ready handshake and decodes each pattern back to a 4-bit hex nibble.
- Packs DIGITS consecutive nibbles into one word and presents it on a valid/ready output, with a sticky error flag for unrecognised patterns.
- Used to read segment data back out of display-driving logic for checking or loopback.

Parameters:
- DIGITS, 4: nibbles per output word; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  seg holds a pattern to consume
- in_ready  output  1  block can accept a pattern this cycle
- seg  input  7  active-low segment pattern, bit 6..0 = segments g..a (0 = lit)
- out_valid  output  1  out_word/out_err hold a complete word
- out_ready  input  1  consumer takes the word this cycle
- out_word  output  4*DIGITS  packed nibbles; first-received digit is most significant
- out_err  output  1  at least one pattern in this word was invalid
- digit_cnt  output  4  nibbles collected so far in the current word

Behaviour:
- Reset is synchronous, active-high. On reset: state=COLLECT, in_ready=1, out_valid=0, out_word=0, out_err=0, digit_cnt=0. A partial word in progress is discarded.
- Decode table (seg hex -> nibble):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9
  - 08->A, 03->B, 27->C, 21->D, 06->E, 0E->F
  - Any other pattern is invalid: it decodes to nibble 0 and sets the sticky error flag.
- FSM has two states, COLLECT and HOLD.
- COLLECT:
  - in_ready=1, out_valid=0.
  - A transfer occurs when in_valid=1 (in_ready=1). The word register shifts left by 4 and the decoded nibble enters at bits [3:0]. digit_cnt increments. The error flag ORs in the invalid indication.
  - When the transfer brings digit_cnt to DIGITS, the next state is HOLD.
  - out_valid rises on the cycle after the last digit is accepted. Latency from last digit to out_valid = 1 cycle.
- HOLD:
  - in_ready=0, out_valid=1. out_word, out_err and digit_cnt (=DIGITS) hold stable while out_ready=0.
  - On out_ready=1: the word is consumed. Next cycle the state returns to COLLECT with digit_cnt=0 and out_err=0. out_word keeps its old value until overwritten by shifting.
  - in_valid is ignored in HOLD, including the same cycle as out_ready. There is no bypass, so at most one word is completed every DIGITS+1 cycles.
- No combinational path from in_valid/out_ready to in_ready/out_valid; both are decoded from the registered state only.
- The error flag is sticky for the whole word and is cleared only at consume or reset.
- seg is sampled only on accepted transfers; its value is don't-care otherwise.

Optional Feature:
- Macro: SEG7_BLANK_SKIP_EN
- Defined: the all-off pattern 7F is accepted (in_ready handshake completes) but discarded. No shift, no digit_cnt change, no error. This allows blanked leading digits to pass through the stream.
- Not defined: 7F is treated like any other invalid pattern (nibble 0, counts as a digit, sets out_err).

Test Plan:
- Reset, then 79,24,30,19 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after the 4th transfer; out_word=16'h1234, out_err=0; COLLECT and in_ready=1 the next cycle.
- 08,03,27,0E with out_ready=0 for 5 cycles while in_valid=1, seg=40 -> out_word stays 16'hABCF, in_ready=0 and digit_cnt=4 throughout. Raise out_ready -> next word starts empty, the pending 40 is accepted only after returning to COLLECT.
- 40,7E,12,00 -> out_word=16'h0058, out_err=1. Next word 02,78,10,21 -> out_word=16'h679D, out_err=0 (sticky flag cleared at consume).
- 79,24 accepted, reset pulsed 1 cycle, then 30,19,40,12 -> out_word=16'h3405; digit_cnt=0 and out_valid=0 immediately after reset.
- in_valid toggling 1,0,1,0,... with 06 each valid cycle -> out_word=16'hEEEE only after 4 actual transfers; digit_cnt steps 0..4 only on valid cycles.
- 7F,79,7F,24,30,19:
  - with SEG7_BLANK_SKIP_EN -> out_word=16'h1234, out_err=0, 6 transfers accepted.
  - without it -> first word 16'h0102 with out_err=1.

Source files
------------

// File: rtl/seg7_word_decoder.sv
// Active-low seven-segment pattern stream to packed hex word decoder.
// Optional macro SEG7_BLANK_SKIP_EN: accept and drop all-off (7F) patterns.
module seg7_word_decoder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            seg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_word,
  output logic                  out_err,
  output logic [3:0]            digit_cnt
);

  localparam int W = 4 * DIGITS;
  localparam logic [3:0] LAST = 4'(DIGITS);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0] state;
  logic [3:0] nib;
  logic       inv;
  logic       blank;
  logic       take;
  logic [3:0] cnt_next;

  // Pattern lookup; unknown patterns map to zero and flag invalid.
  always_comb begin
    nib = 4'h0;
    inv = 1'b0;
    case (seg)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h27: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: inv = 1'b1;
    endcase
  end

`ifdef SEG7_BLANK_SKIP_EN
  assign blank = (seg == 7'h7F);
`else
  assign blank = 1'b0;
`endif

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign take      = in_valid && !blank;
  assign cnt_next  = digit_cnt + 4'd1;

  // Collect digits into the word, then hold it until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      out_word  <= '0;
      out_err   <= 1'b0;
      digit_cnt <= 4'd0;
    end else begin
      case (state)
        COLLECT: begin
          if (take) begin
            out_word  <= (out_word << 4) | W'(nib);
            out_err   <= out_err | inv;
            digit_cnt <= cnt_next;
            if (cnt_next == LAST)
              state <= HOLD;
          end
        end
        default: begin
          if (out_ready) begin
            state     <= COLLECT;
            out_err   <= 1'b0;
            digit_cnt <= 4'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_word_decoder.sv
// Directed self-checking bench for seg7_word_decoder.
// Covers both builds of SEG7_BLANK_SKIP_EN.
module tb_seg7_word_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  seg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic        out_err;
  logic [3:0]  digit_cnt;

  int checks;
  int errors;
  int acc;

  seg7_word_decoder #(.DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .seg       (seg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_err   (out_err),
    .digit_cnt (digit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] s);
    in_valid = 1'b1;
    seg = s;
    if (in_ready) acc++;
    step();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (out_word !== 16'h0 || out_err !== 1'b0 || digit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs w=%h e=%b c=%0d want 0 0 0",
               out_word, out_err, digit_cnt);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(7'h79);
    send(7'h24);
    send(7'h30);
    checks++;
    if (out_valid !== 1'b0 || digit_cnt !== 4'd3) begin
      errors++;
      $display("FAIL basic_early vld=%b c=%0d want 0 3", out_valid, digit_cnt);
    end
    send(7'h19);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_lat vld=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    checks++;
    if (out_word !== 16'h1234 || out_err !== 1'b0 || digit_cnt !== 4'd4) begin
      errors++;
      $display("FAIL basic_word w=%h e=%b c=%0d want 1234 0 4",
               out_word, out_err, digit_cnt);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || digit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL basic_back rdy=%b vld=%b c=%0d want 1 0 0",
               in_ready, out_valid, digit_cnt);
    end
  endtask

  task automatic test_hold();
    send(7'h08);
    send(7'h03);
    send(7'h27);
    send(7'h0E);
    in_valid = 1'b1;
    seg = 7'h40;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_word !== 16'hABCF || in_ready !== 1'b0 ||
          digit_cnt !== 4'd4 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d w=%h rdy=%b c=%0d vld=%b want abcf 0 4 1",
                 i, out_word, in_ready, digit_cnt, out_valid);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (digit_cnt !== 4'd0 || in_ready !== 1'b1 || out_word !== 16'hABCF) begin
      errors++;
      $display("FAIL hold_release c=%0d rdy=%b w=%h want 0 1 abcf",
               digit_cnt, in_ready, out_word);
    end
    step();
    checks++;
    if (digit_cnt !== 4'd1 || out_word !== 16'hBCF0) begin
      errors++;
      $display("FAIL hold_pending c=%0d w=%h want 1 bcf0", digit_cnt, out_word);
    end
    in_valid = 1'b0;
    send(7'h40);
    send(7'h40);
    send(7'h40);
    checks++;
    if (out_word !== 16'h0000 || out_valid !== 1'b1 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL hold_zero w=%h vld=%b e=%b want 0000 1 0",
               out_word, out_valid, out_err);
    end
    consume();
  endtask

  task automatic test_error();
    send(7'h40);
    send(7'h7E);
    checks++;
    if (out_err !== 1'b1) begin
      errors++;
      $display("FAIL err_mid e=%b want 1", out_err);
    end
    send(7'h12);
    send(7'h00);
    checks++;
    if (out_word !== 16'h0058 || out_err !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL err_word w=%h e=%b vld=%b want 0058 1 1",
               out_word, out_err, out_valid);
    end
    consume();
    checks++;
    if (out_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear e=%b want 0", out_err);
    end
    send(7'h02);
    send(7'h78);
    send(7'h10);
    send(7'h21);
    checks++;
    if (out_word !== 16'h679D || out_err !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL err_next w=%h e=%b vld=%b want 679d 0 1",
               out_word, out_err, out_valid);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    send(7'h79);
    send(7'h24);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (digit_cnt !== 4'd0 || out_valid !== 1'b0 || out_word !== 16'h0) begin
      errors++;
      $display("FAIL mrst_state c=%0d vld=%b w=%h want 0 0 0000",
               digit_cnt, out_valid, out_word);
    end
    send(7'h30);
    send(7'h19);
    send(7'h40);
    send(7'h12);
    checks++;
    if (out_word !== 16'h3405 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mrst_word w=%h vld=%b want 3405 1", out_word, out_valid);
    end
    consume();
  endtask

  task automatic test_toggle();
    logic [3:0] exp_c;
    seg = 7'h06;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      step();
      exp_c = 4'(i / 2 + 1);
      checks++;
      if (digit_cnt !== exp_c) begin
        errors++;
        $display("FAIL toggle_%0d c=%0d want %0d", i, digit_cnt, exp_c);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_word !== 16'hEEEE || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL toggle_word w=%h vld=%b want eeee 1", out_word, out_valid);
    end
    consume();
  endtask

  task automatic test_blank();
    acc = 0;
    send(7'h7F);
    send(7'h79);
    send(7'h7F);
    send(7'h24);
`ifdef SEG7_BLANK_SKIP_EN
    send(7'h30);
    send(7'h19);
    checks++;
    if (out_word !== 16'h1234 || out_err !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL blank_word w=%h e=%b vld=%b want 1234 0 1",
               out_word, out_err, out_valid);
    end
    checks++;
    if (acc !== 6) begin
      errors++;
      $display("FAIL blank_acc got %0d want 6", acc);
    end
    consume();
`else
    checks++;
    if (out_word !== 16'h0102 || out_err !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL blank_word w=%h e=%b vld=%b want 0102 1 1",
               out_word, out_err, out_valid);
    end
    consume();
    send(7'h30);
    send(7'h19);
    checks++;
    if (digit_cnt !== 4'd2 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL blank_tail c=%0d e=%b want 2 0", digit_cnt, out_err);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    acc = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    seg = 7'h7F;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_error();
    test_mid_reset();
    test_toggle();
    test_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
